// File: rtl/booth_div.sv
// Sequential signed divider: non-restoring division on operand magnitudes,
// one WIDTH+1-bit add/subtract per clock, then remainder correction and sign fix-up.
module booth_div #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             ovf
);

    typedef enum logic [2:0] {IDLE, PREP, ITER, CORR, SIGN} state_t;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH:0]   d_mag_q, d_mag_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   p_step;
    logic [WIDTH-1:0] q_signed;
    logic [WIDTH-1:0] r_signed;
    logic             is_zero;
    logic             is_ovf;

    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        q_d       = q_q;
        p_d       = p_q;
        d_mag_d   = d_mag_q;
        cnt_d     = cnt_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dz_d      = dz_q;
        ovf_d     = ovf_q;

        // Shift {P,Q} left; add or subtract |D| depending on the sign of the old P.
        p_shift  = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
        p_step   = p_q[WIDTH] ? (p_shift + d_mag_q) : (p_shift - d_mag_q);
        q_signed = quo_neg_q ? (WIDTH'(0) - q_q) : q_q;
        r_signed = rem_neg_q ? (WIDTH'(0) - p_q[WIDTH-1:0]) : p_q[WIDTH-1:0];
        is_zero  = (dvs_q == '0);
        is_ovf   = (dvd_q == MOST_NEG) && (dvs_q == '1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = dividend_in;
                    dvs_d   = divisor_in;
                    busy_d  = 1'b1;
                    state_d = PREP;
                end
            end
            PREP: begin
                quo_neg_d = dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1];
                rem_neg_d = dvd_q[WIDTH-1];
                // Unsigned WIDTH-bit magnitude: the most negative value maps to 2^(WIDTH-1).
                q_d       = dvd_q[WIDTH-1] ? (WIDTH'(0) - dvd_q) : dvd_q;
                d_mag_d   = {1'b0, (dvs_q[WIDTH-1] ? (WIDTH'(0) - dvs_q) : dvs_q)};
                p_d       = '0;
                cnt_d     = '0;
                state_d   = ITER;
            end
            ITER: begin
                p_d   = p_step;
                q_d   = {q_q[WIDTH-2:0], ~p_step[WIDTH]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = CORR;
                end
            end
            CORR: begin
                if (p_q[WIDTH]) begin
                    p_d = p_q + d_mag_q;
                end
                state_d = SIGN;
            end
            SIGN: begin
                if (is_zero) begin
                    quo_d = '1;
                    rem_d = dvd_q;
                    dz_d  = 1'b1;
                    ovf_d = 1'b0;
                end else if (is_ovf) begin
                    quo_d = MOST_NEG;
                    rem_d = '0;
                    dz_d  = 1'b0;
                    ovf_d = 1'b1;
                end else begin
                    quo_d = q_signed;
                    rem_d = r_signed;
                    dz_d  = 1'b0;
                    ovf_d = 1'b0;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dvd_q     <= '0;
            dvs_q     <= '0;
            q_q       <= '0;
            p_q       <= '0;
            d_mag_q   <= '0;
            cnt_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            q_q       <= q_d;
            p_q       <= p_d;
            d_mag_q   <= d_mag_d;
            cnt_q     <= cnt_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign div_zero  = dz_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_booth_div.sv
// Self-checking bench for booth_div: directed vector table, multi-cycle corner
// sequences and randomized operands against an integer-arithmetic reference.
module tb_booth_div;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend_in;
    logic [W-1:0] divisor_in;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
    } vec_t;

    vec_t vecs[9];

    booth_div #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend_in(dividend_in),
        .divisor_in (divisor_in),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference: plain signed integer division (truncating, remainder follows dividend).
    task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r,
                           output logic dz, output logic ov);
        int ia;
        int ib;
        int qi;
        int ri;
        ia = int'($signed(a));
        ib = int'($signed(b));
        if (ib == 0) begin
            q = '1; r = a; dz = 1'b1; ov = 1'b0;
        end else if (ia == -(2 ** (W - 1)) && ib == -1) begin
            q = 16'h8000; r = '0; dz = 1'b0; ov = 1'b1;
        end else begin
            qi = ia / ib;
            ri = ia % ib;
            q = qi[W-1:0]; r = ri[W-1:0]; dz = 1'b0; ov = 1'b0;
        end
    endtask

    // Present operands now and hold start across exactly one rising edge.
    task automatic start_now(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend_in = a;
        divisor_in  = b;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start       = 1'b0;
        dividend_in = W'($urandom);
        divisor_in  = W'($urandom);
    endtask

    task automatic check_op(input string nm, input int exp_lat,
                            input logic [W-1:0] eq, input logic [W-1:0] er,
                            input logic edz, input logic eov);
        int   lat;
        logic busy_ok;
        lat = 0;
        busy_ok = 1'b1;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
        end
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_busy_during"}, busy_ok, 1'b1);
        chk({nm, "_busy_at_done"}, busy, 1'b0);
        chk({nm, "_quotient"}, quotient, eq);
        chk({nm, "_remainder"}, remainder, er);
        chk({nm, "_flags"}, {div_zero, ovf}, {edz, eov});
    endtask

    initial begin
        logic [W-1:0] ra, rb, rq, rr;
        logic         rdz, rov;
        logic         seen;

        vecs[0] = '{16'd1034,  16'd526,   16'd1,      16'd508,    1'b0, 1'b0};
        vecs[1] = '{16'hFBF6,  16'd526,   16'hFFFF,   16'hFE04,   1'b0, 1'b0};
        vecs[2] = '{16'd1034,  16'hFDF2,  16'hFFFF,   16'd508,    1'b0, 1'b0};
        vecs[3] = '{16'hFBF6,  16'hFDF2,  16'd1,      16'hFE04,   1'b0, 1'b0};
        vecs[4] = '{16'd100,   16'd0,     16'hFFFF,   16'd100,    1'b1, 1'b0};
        vecs[5] = '{16'd7,     16'd2,     16'd3,      16'd1,      1'b0, 1'b0};
        vecs[6] = '{16'h8000,  16'hFFFF,  16'h8000,   16'd0,      1'b0, 1'b1};
        vecs[7] = '{16'h8000,  16'd1,     16'h8000,   16'd0,      1'b0, 1'b0};
        vecs[8] = '{16'h7FFF,  16'h8000,  16'd0,      16'h7FFF,   1'b0, 1'b0};

        rst = 1'b1;
        start = 1'b0;
        dividend_in = '0;
        divisor_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {quotient, remainder, busy, done, div_zero, ovf}, '0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            start_now(vecs[i].a, vecs[i].b);
            check_op($sformatf("vec%0d", i), 19, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].ov);
        end

        // Start while busy is ignored; start in the done cycle is accepted.
        @(negedge clk);
        start_now(16'd1034, 16'd526);
        repeat (4) @(posedge clk);
        #1;
        start_now(16'd5, 16'd5);
        check_op("ignored_start", 14, 16'd1, 16'd508, 1'b0, 1'b0);
        start_now(16'd5, 16'd5);
        check_op("done_cycle_start", 19, 16'd1, 16'd0, 1'b0, 1'b0);

        // Reset mid-operation aborts without a done pulse.
        @(negedge clk);
        start_now(16'd1034, 16'd526);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_outputs", {quotient, remainder, busy, done, div_zero, ovf}, '0);
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1'b1;
        end
        chk("abort_no_done", seen, 1'b0);
        start_now(16'd9, 16'd4);
        check_op("after_abort", 19, 16'd2, 16'd1, 1'b0, 1'b0);

        for (int n = 0; n < 250; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = '1;
                2: ra = 16'h8000;
                3: begin ra = 16'h8000; rb = '1; end
                4: rb = W'($urandom_range(1, 15));
                default: ;
            endcase
            ref_div(ra, rb, rq, rr, rdz, rov);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            start_now(ra, rb);
            check_op("rand", 19, rq, rr, rdz, rov);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_div.md
Name: booth_div

Overview:
- Sequential signed two's-complement divider; the inverse operation to the team's multiplier.
- Built around one WIDTH+1-bit add/subtract step per clock, using non-restoring division on operand magnitudes, followed by sign fix-up.
- Sits beside the multiplier in the arithmetic unit and uses the same start/done handshake style.
- Fixed latency, one operation in flight at a time.

Parameters:
WIDTH, 16, operand/result width in bits; the internal partial remainder is WIDTH+1 bits.

Ports:
clk  input  1  single clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
dividend_in  input  WIDTH  signed dividend, captured on the accepted start edge
divisor_in  input  WIDTH  signed divisor, captured on the accepted start edge
quotient  output  WIDTH  signed quotient, held until the next done
remainder  output  WIDTH  signed remainder, held until the next done
busy  output  1  high from the accepting edge until the edge that raises done
done  output  1  one-cycle pulse; results are valid in that cycle
div_zero  output  1  divisor was 0; valid with done, held with results
ovf  output  1  most-negative / -1 case; valid with done, held with results

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; quotient=0, remainder=0, busy=0, done=0, div_zero=0, ovf=0. Reset overrides start and aborts any operation in progress. No done is produced for an aborted operation.
- FSM states: IDLE, PREP, ITER, CORR, SIGN.
- IDLE:
  - start=1 → latch operands, busy=1, go to PREP.
  - start=0 → stay in IDLE.
  - done is low in every state except the cycle after SIGN.
- PREP:
  - Record sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - Take magnitudes, zero-extended to WIDTH+1. The magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), with no wrap.
  - Clear the partial remainder P (WIDTH+1 bits) and the iteration counter; go to ITER.
- ITER, WIDTH cycles, one per edge:
  - Shift {P, Q} left by 1.
  - If the old P >= 0, P = P - |D|; otherwise P = P + |D|.
  - Q[0] = ~P_new[WIDTH].
  - After WIDTH iterations go to CORR.
- CORR: if P < 0, P = P + |D|; go to SIGN.
- SIGN: load the registered outputs; done=1 for the following cycle; busy=0; return to IDLE.
  - quotient = sign_q ? -Q : Q, truncated toward zero.
  - remainder = sign_r ? -P : P. The remainder sign follows the dividend, and |remainder| < |divisor|.
- Latency:
  - Start accepted at edge 0; done is high in the cycle after edge WIDTH+3, i.e. 19 clocks for WIDTH=16.
  - Latency is identical for all operands, including the exception cases.
- Back-to-back: start may be asserted in the done cycle; busy=0 then, so it is accepted.
- start while busy=1 is ignored. The captured operands are unaffected and the in-flight result is unchanged.
- Divide by zero (divisor=0):
  - quotient = all ones, remainder = dividend, div_zero=1, ovf=0.
  - The iterations run but their result is overridden in SIGN.
- Overflow (dividend = -2^(WIDTH-1) and divisor = -1): quotient = 2^(WIDTH-1) as a bit pattern (0x8000), remainder = 0, ovf=1, div_zero=0.
- Flags: div_zero and ovf are updated only in SIGN and cleared by normal operations.
- Operands may change freely after acceptance.

Test Plan:
- rst=1 for 2 cycles, then dividend=1034, divisor=526, start for 1 cycle → done exactly 19 clocks later; quotient=1, remainder=508, flags 0; busy high for those 19 cycles.
- -1034/526 → quotient=0xFFFF (-1), remainder=0xFE04 (-508). Then 1034/-526 → quotient=0xFFFF, remainder=508. Then -1034/-526 → quotient=1, remainder=0xFE04.
- 100/0 → div_zero=1, quotient=0xFFFF, remainder=100, same 19-clock latency. A following 7/2 → quotient=3, remainder=1, div_zero=0.
- -32768/-1 → ovf=1, quotient=0x8000, remainder=0. Then -32768/1 → quotient=0x8000, remainder=0, ovf=0. Then 32767/-32768 → quotient=0, remainder=32767.
- Assert start with 5/5 at cycle 5 of an active 1034/526 operation → ignored; result is 1/508. Then start with 5/5 in the done cycle → accepted; result 1/0 after 19 clocks.
- rst=1 at cycle 10 of an operation → busy=0, done never pulses, all outputs 0. A new 9/4 afterward → quotient=2, remainder=1.
